// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: multi-stage pipeline for the decoded control word
// (Decode -> E -> M -> W). Every stage has its own valid bit, stall and
// flush. A stall holds its own stage and all upstream stages, and it
// injects a bubble into the first downstream stage that is free to move.
// A saturating counter tracks the cycles in which the last stage holds a
// bubble, which supports CPI measurement.
//
// Handshake: in_ready is high when stage 0 will capture d_in on the next
// rising edge. A d_in presented while in_ready is low is dropped, so the
// producer must hold it until a cycle with in_ready high. valid_in only
// qualifies d_in. It never gates capture.
module ctrl_pipe_chain #(
  parameter int               WIDTH   = 14,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] NOP_VAL = {WIDTH{1'b0}},
  parameter int               CW      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       d_in,
  input  logic                   valid_in,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  input  logic                   cnt_clr,
  output logic [DEPTH*WIDTH-1:0] q_out,
  output logic [DEPTH-1:0]       valid_out,
  output logic                   in_ready,
  output logic [CW-1:0]          bubble_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [DEPTH-1:0][WIDTH-1:0] word_q, word_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  // es[k]: stage k is held by its own stall or by any downstream stall.
  logic [DEPTH-1:0]            es;
  // es_up[k] = es[k-1] (0 for stage 0): the stage above k is held, so k takes a bubble.
  logic [DEPTH-1:0]            es_up;
  // src_*[k]: what stage k loads when it advances (d_in for stage 0).
  logic [DEPTH:0][WIDTH-1:0]   src_word;
  logic [DEPTH:0]              src_valid;

  assign src_word  = {word_q, d_in};
  assign src_valid = {valid_q, valid_in};
  assign es_up     = es << 1;

  // Effective stall: OR-reduce stall from each stage down to the last one.
  always_comb begin
    es = '0;
    es[DEPTH-1] = stall[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      es[k] = stall[k] | es[k+1];
    end
  end

  // Per-stage next state: flush, then hold, then bubble, then advance.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush[k]) begin
        word_d[k]  = NOP_VAL;
        valid_d[k] = 1'b0;
      end else if (es[k]) begin
        word_d[k]  = word_q[k];
        valid_d[k] = valid_q[k];
      end else if (es_up[k]) begin
        word_d[k]  = NOP_VAL;
        valid_d[k] = 1'b0;
      end else begin
        word_d[k]  = src_word[k];
        valid_d[k] = src_valid[k];
      end
    end
  end

  // Bubble counter next state: clear wins, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!valid_q[DEPTH-1] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stage registers and counter; async reset makes outputs NOP immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q  <= {DEPTH{NOP_VAL}};
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Force invalid stages to NOP so consumers never need to gate the word.
  always_comb begin
    q_out = '0;
    for (int k = 0; k < DEPTH; k++) begin
      q_out[k*WIDTH +: WIDTH] = valid_q[k] ? word_q[k] : NOP_VAL;
    end
  end

  assign valid_out  = valid_q;
  assign in_ready   = ~es[0] & ~flush[0];
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain (WIDTH=14, DEPTH=3, CW=4).
module tb_ctrl_pipe_chain;

  localparam int WIDTH = 14;
  localparam int DEPTH = 3;
  localparam int CW    = 4;

  logic                   clk;
  logic                   reset;
  logic [WIDTH-1:0]       d_in;
  logic                   valid_in;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       flush;
  logic                   cnt_clr;
  logic [DEPTH*WIDTH-1:0] q_out;
  logic [DEPTH-1:0]       valid_out;
  logic                   in_ready;
  logic [CW-1:0]          bubble_cnt;

  logic [WIDTH-1:0] s0, s1, s2;
  assign s0 = q_out[0*WIDTH +: WIDTH];
  assign s1 = q_out[1*WIDTH +: WIDTH];
  assign s2 = q_out[2*WIDTH +: WIDTH];

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  ctrl_pipe_chain #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .NOP_VAL({WIDTH{1'b0}}),
    .CW     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .valid_in  (valid_in),
    .stall     (stall),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .q_out     (q_out),
    .valid_out (valid_out),
    .in_ready  (in_ready),
    .bubble_cnt(bubble_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] w, input logic v);
    d_in     = w;
    valid_in = v;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: the last stage must deliver the queued words in order
  task automatic sb_check(input string tag);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {valid_out[2], s2}, {1'b1, e});
    end
  endtask

  initial begin
    reset = 1'b1; stall = '0; flush = '0; cnt_clr = 1'b0;
    drive('0, 1'b0);

    // reset state, asserted asynchronously
    #1 reset = 1'b0;
    #2;
    chk("rst_q", q_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_cnt", bubble_cnt, 0);
    tick(); tick();
    reset = 1'b1;

    // straight flow
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("flow_cnt0", bubble_cnt, 0);
    exp_q.push_back(14'h111); exp_q.push_back(14'h222); exp_q.push_back(14'h333);
    drive(14'h111, 1'b1); tick();
    drive(14'h222, 1'b1); tick();
    drive(14'h333, 1'b1); tick();
    sb_check("flow_s2_a");
    chk("flow_valid3", valid_out, 3'b111);
    chk("flow_cnt3", bubble_cnt, 3);
    drive(14'h155, 1'b0); tick();
    sb_check("flow_s2_b");
    chk("flow_cnt_hold", bubble_cnt, 3);
    chk("flow_gate_s0", s0, 0);
    chk("flow_valid4", valid_out, 3'b110);
    drive('0, 1'b0); tick();
    sb_check("flow_s2_c");
    chk("flow_valid5", valid_out, 3'b100);
    chk("flow_sb_left", exp_q.size(), 0);
    tick(); tick();

    // load-use stall on stage 0
    drive(14'h2C4, 1'b1); tick();
    drive(14'h2C5, 1'b1); tick();
    stall = 3'b001; drive(14'h2C6, 1'b1);
    #1 chk("lu_ready", in_ready, 0);
    tick();
    chk("lu_s0_hold", s0, 14'h2C5);
    chk("lu_s1_nop", s1, 0);
    chk("lu_s2", s2, 14'h2C4);
    chk("lu_valid", valid_out, 3'b101);
    stall = 3'b000;
    tick();
    chk("lu_s0_next", s0, 14'h2C6);
    chk("lu_s1", s1, 14'h2C5);
    chk("lu_valid2", valid_out, 3'b011);
    drive('0, 1'b0); tick();
    chk("lu_s2_late", s2, 14'h2C5);
    chk("lu_valid3", valid_out, 3'b110);

    // downstream stall on stage 1
    drive(14'h303, 1'b1); tick();
    drive(14'h202, 1'b1); tick();
    drive(14'h101, 1'b1); cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("ds_fill", {s0, s1, s2}, {14'h101, 14'h202, 14'h303});
    chk("ds_cnt0", bubble_cnt, 0);
    drive('0, 1'b0); stall = 3'b010;
    tick();
    chk("ds_hold1", {s0, s1, s2}, {14'h101, 14'h202, 14'h000});
    chk("ds_valid1", valid_out, 3'b011);
    tick();
    chk("ds_hold2", {s0, s1, s2}, {14'h101, 14'h202, 14'h000});
    chk("ds_valid2", valid_out, 3'b011);
    chk("ds_cnt1", bubble_cnt, 1);
    stall = 3'b000;
    tick();
    chk("ds_cnt2", bubble_cnt, 2);
    chk("ds_release", {s1, s2}, {14'h101, 14'h202});
    chk("ds_valid3", valid_out, 3'b110);

    // flush together with stall
    drive(14'h0F0, 1'b1); tick();
    drive(14'h0F1, 1'b1); tick();
    stall = 3'b001; flush = 3'b011; drive(14'h3AA, 1'b1);
    #1 chk("fs_ready", in_ready, 0);
    tick();
    chk("fs_words", {s0, s1, s2}, {14'h000, 14'h000, 14'h0F0});
    chk("fs_valid", valid_out, 3'b100);
    stall = 3'b000; flush = 3'b000; drive('0, 1'b0);
    tick();
    chk("fs_not_captured", valid_out, 3'b000);

    // counter saturation
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("sat_clr0", bubble_cnt, 0);
    repeat (20) tick();
    chk("sat_max", bubble_cnt, 15);
    tick();
    chk("sat_hold", bubble_cnt, 15);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("sat_clr", bubble_cnt, 0);
    tick();
    chk("sat_resume", bubble_cnt, 1);

    // reset mid-stream
    drive(14'h0A1, 1'b1); tick();
    drive(14'h0A2, 1'b1); tick();
    drive(14'h0A3, 1'b1); tick();
    drive('0, 1'b0);
    chk("mr_full", {valid_out, s0, s1, s2}, {3'b111, 14'h0A3, 14'h0A2, 14'h0A1});
    #2 reset = 1'b0;
    #1;
    chk("mr_q", q_out, 0);
    chk("mr_valid", valid_out, 0);
    chk("mr_cnt", bubble_cnt, 0);
    chk("mr_ready", in_ready, 1);
    #5 reset = 1'b1;
    tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_chain.md
# ctrl_pipe_chain

Parametrised multi-stage control-signal pipeline for the RV32I core. It carries the decoded control word (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, AOperand, ForwardValMux, …) from Decode through Execute, Memory and Writeback as one packed vector. Each stage has its own valid bit, stall and flush, and a stall automatically inserts a bubble downstream. A saturating bubble counter on the last stage supports CPI measurement.

## Interface
Parameters:
- WIDTH, 14: bits per control word; must be ≥ 1.
- DEPTH, 3: number of stages (stage 0 = E, 1 = M, 2 = W); must be ≥ 1.
- NOP_VAL, {WIDTH{1'b0}}: word loaded on reset, flush and bubble insertion.
- CW, 16: bubble counter width; must be ≥ 1.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- d_in, input, WIDTH: control word from Decode.
- valid_in, input, 1: d_in holds a real instruction.
- stall, input, DEPTH: per-stage hold request; bit k holds stage k.
- flush, input, DEPTH: per-stage kill; bit k turns stage k into NOP.
- cnt_clr, input, 1: synchronous clear of bubble_cnt.
- q_out, output, DEPTH*WIDTH: stage k word at bits [k*WIDTH +: WIDTH].
- valid_out, output, DEPTH: per-stage valid.
- in_ready, output, 1: stage 0 accepts d_in this cycle.
- bubble_cnt, output, CW: count of cycles the last stage held a bubble.

## Operation
- Effective stall: es[k] = OR of stall[k] through stall[DEPTH-1]. A stall therefore holds its own stage and every upstream stage.
- Per-stage next state, in priority order:
  - reset low: word = NOP_VAL, valid = 0.
  - flush[k]: word = NOP_VAL, valid = 0, even when es[k] = 1.
  - es[k]: hold the current word and valid.
  - k > 0 and es[k-1] = 1 (equivalent to stall[k-1] = 1 with es[k] = 0): load a bubble, i.e. NOP_VAL with valid = 0.
  - otherwise advance: stage 0 loads d_in/valid_in; stage k loads stage k-1.
- When valid_in = 0, stage 0 still loads d_in as presented. Upstream logic supplies NOP_VAL as d_in in that case.
- Every output word is forced to NOP_VAL whenever its valid is 0. Downstream logic can use the word without gating.
- in_ready = ~es[0] & ~flush[0]. A d_in presented while in_ready = 0 is not captured and must be re-presented.
- bubble_cnt:
  - Each rising edge with valid_out[DEPTH-1] = 0 adds 1, saturating at 2^CW−1.
  - cnt_clr has priority over increment and loads 0.
  - Reset loads 0.
- Flushing a stage does not affect its neighbours. A flushed stage that is also held stays a bubble until released.

## Timing
- Latency: d_in reaches stage k output k+1 cycles after capture when no stall occurs.
- Reset values: q_out = {DEPTH{NOP_VAL}}, valid_out = 0, in_ready = 1, bubble_cnt = 0.
  - All outputs take these values immediately on reset assertion, without waiting for a clock edge.
  - Release of reset is synchronous to clk. The first capture happens on the first rising edge after release.
- The stall, flush and cnt_clr vectors are sampled on the same edge as data. They have no combinational path to q_out or valid_out.
- in_ready is combinational from stall and flush only.
- Simultaneous stall[k] and flush[k]: flush wins. Upstream stages are still held because of es.
- Simultaneous flush[k] and a bubble condition: the result is identical (NOP, invalid).
- Counter saturation: once bubble_cnt = 2^CW−1 it holds that value until cnt_clr or reset.
- DEPTH = 1: no bubble insertion path exists; stage 0 obeys only reset, flush, stall and advance.

## Test plan
- Reset mid-stream: fill all 3 stages with valid words 0x0A1, 0x0A2, 0x0A3, then pull reset low between clock edges. Required: q_out = 0 and valid_out = 3'b000 immediately; bubble_cnt = 0; in_ready = 1.
- Straight flow: present 0x111, 0x222, 0x333 on consecutive cycles. Required: 0x111 appears at stage 2 on cycle 3; valid_out = 3'b111 on cycle 3; bubble_cnt stops incrementing from cycle 3.
- Load-use stall: hold stall = 3'b001 for 1 cycle while stage 0 = 0x2C5. Required:
  - stage 0 keeps 0x2C5;
  - stage 1 becomes NOP with valid_out[1] = 0;
  - in_ready = 0 during the stall;
  - 0x2C5 reaches stage 2 one cycle later than in the unstalled flow.
- Downstream stall propagation: stall = 3'b010 for 2 cycles with stages = 0x101/0x202/0x303. Required:
  - stages 0 and 1 hold;
  - stage 2 receives bubbles;
  - bubble_cnt increases by 2.
- Flush vs stall: assert stall = 3'b001 and flush = 3'b011 together. Required:
  - stages 0 and 1 become NOP and invalid;
  - stage 2 advances normally;
  - the d_in presented that cycle is not captured.
- Counter saturation (CW = 4): run 20 idle cycles. Required: bubble_cnt = 15 and holds; cnt_clr for 1 cycle gives 0, then counting resumes at 1 on the next idle cycle.
